mio_bus: RTL and testbench

// - Memory/IO bus slave that serves the multi-cycle CPU controller's MemRead/MemWrite/CPU_MIO requests and returns MIO_ready.
// - Decodes each address to RAM or peripheral space, inserts wait states, captures read data into Data_in.
// - Sits directly downstream of the CPU controller and upstream of the data RAM and the IO peripheral block.

---
 rtl/mio_bus_if.sv | 21 ++
 rtl/mio_bus.sv | 163 ++++++++++++++++
 tb/tb_mio_bus.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_if.sv
// CPU-side request/response bundle for mio_bus: the controller drives the master
// modport and mio_bus sits on the slave modport.
interface mio_bus_if;
  logic        MemRead;
  logic        MemWrite;
  logic        CPU_MIO;
  logic [31:0] addr_bus;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;

  modport master (
    output MemRead, MemWrite, CPU_MIO, addr_bus, Data_out,
    input  Data_in, MIO_ready
  );

  modport slave (
    input  MemRead, MemWrite, CPU_MIO, addr_bus, Data_out,
    output Data_in, MIO_ready
  );
endinterface

// File: rtl/mio_bus.sv
// Memory/IO bus slave: decodes CPU requests to RAM or peripheral space, inserts wait
// states and returns a one-cycle MIO_ready. Define MIO_TIMEOUT_EN for io_ack/timeout mode.
module mio_bus #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 0,
  parameter int IO_WAIT  = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_if.slave          cpu,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              io_rd,
  output logic              io_we,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_din,
`ifdef MIO_TIMEOUT_EN
  input  logic              io_ack,
  output logic              bus_err,
`endif
  input  logic [31:0]       io_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  // Wait counts are 4 bits wide; larger parameters wrap mod 16.
  localparam logic [3:0] RAM_WC = 4'(RAM_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  wc_sel;
  logic        sel_io_q, is_wr_q;
  logic        req, sel_io_in;
  logic [31:0] io_rdata;

  assign req       = (cpu.MemRead | cpu.MemWrite) & cpu.CPU_MIO;
  assign sel_io_in = (cpu.addr_bus[31:29] == 3'b111);

`ifdef MIO_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LD = TW'(TIMEOUT);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timed_out;

  // Ack on the expiry cycle wins over the timeout.
  assign timed_out = (state_q == S_WAIT) && sel_io_q && !io_ack && (tcnt_q == TW'(1));
  assign wc_sel    = RAM_WC;
  assign io_rdata  = timed_out ? 32'hDEAD_BEEF : io_dout;
`else
  localparam logic [3:0] IO_WC = 4'(IO_WAIT);

  assign wc_sel   = sel_io_q ? IO_WC : RAM_WC;
  assign io_rdata = io_dout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
`ifdef MIO_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
`ifdef MIO_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
`ifdef MIO_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      S_IDLE: if (req) state_d = S_ACCESS;
      S_ACCESS: begin
`ifdef MIO_TIMEOUT_EN
        if (sel_io_q) begin
          state_d = S_WAIT;
          tcnt_d  = TO_LD;
        end else
`endif
        if (wc_sel != 4'd0) begin
          state_d = S_WAIT;
          wcnt_d  = wc_sel;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
`ifdef MIO_TIMEOUT_EN
        if (sel_io_q) begin
          tcnt_d = tcnt_q - TW'(1);
          if (io_ack || (tcnt_q == TW'(1))) state_d = S_DONE;
        end else
`endif
        begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs; request fields are captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_io_q      <= 1'b0;
      is_wr_q       <= 1'b0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_din       <= '0;
      io_rd         <= 1'b0;
      io_we         <= 1'b0;
      io_addr       <= '0;
      io_din        <= '0;
      cpu.Data_in   <= '0;
      cpu.MIO_ready <= 1'b0;
`ifdef MIO_TIMEOUT_EN
      bus_err       <= 1'b0;
`endif
    end else begin
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      io_rd         <= 1'b0;
      io_we         <= 1'b0;
      cpu.MIO_ready <= (state_d == S_DONE);
      if ((state_q == S_IDLE) && req) begin
        sel_io_q <= sel_io_in;
        is_wr_q  <= cpu.MemWrite;
        if (sel_io_in) begin
          io_rd   <= ~cpu.MemWrite;
          io_we   <= cpu.MemWrite;
          io_addr <= cpu.addr_bus;
          io_din  <= cpu.Data_out;
        end else begin
          ram_en   <= 1'b1;
          ram_we   <= cpu.MemWrite;
          ram_addr <= cpu.addr_bus[RAM_AW+1:2];
          ram_din  <= cpu.Data_out;
        end
      end
      if ((state_d == S_DONE) && !is_wr_q)
        cpu.Data_in <= sel_io_q ? io_rdata : ram_dout;
`ifdef MIO_TIMEOUT_EN
      if (timed_out) bus_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mio_bus.sv
// Directed bench for mio_bus: two instances (RAM_WAIT=0 and RAM_WAIT=3) with a
// scoreboard of expected completion latency and read data per transaction.
module tb_mio_bus;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mio_bus_if b0();
  mio_bus_if b1();

  logic          o_ram_en [2];
  logic          o_ram_we [2];
  logic          o_io_rd [2];
  logic          o_io_we [2];
  logic [AW-1:0] o_ram_addr [2];
  logic [31:0]   o_ram_din [2];
  logic [31:0]   o_io_addr [2];
  logic [31:0]   o_io_din [2];
  logic [31:0]   i_ram_dout [2];
  logic [31:0]   io_val;
`ifdef MIO_TIMEOUT_EN
  logic          io_ack;
  logic          o_bus_err [2];
`endif

  function automatic logic [31:0] ram_model(input logic [AW-1:0] a);
    return (a == AW'(4)) ? 32'h1234_5678 : (32'h5A00_0000 | 32'(a));
  endfunction

  assign i_ram_dout[0] = ram_model(o_ram_addr[0]);
  assign i_ram_dout[1] = ram_model(o_ram_addr[1]);

  mio_bus #(.RAM_AW(AW), .RAM_WAIT(0), .IO_WAIT(2), .TIMEOUT(8)) u_dut0 (
    .clk(clk), .reset(reset), .cpu(b0),
    .ram_en(o_ram_en[0]), .ram_we(o_ram_we[0]), .ram_addr(o_ram_addr[0]),
    .ram_din(o_ram_din[0]), .ram_dout(i_ram_dout[0]),
    .io_rd(o_io_rd[0]), .io_we(o_io_we[0]), .io_addr(o_io_addr[0]), .io_din(o_io_din[0]),
`ifdef MIO_TIMEOUT_EN
    .io_ack(io_ack), .bus_err(o_bus_err[0]),
`endif
    .io_dout(io_val)
  );

  mio_bus #(.RAM_AW(AW), .RAM_WAIT(3), .IO_WAIT(2), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .reset(reset), .cpu(b1),
    .ram_en(o_ram_en[1]), .ram_we(o_ram_we[1]), .ram_addr(o_ram_addr[1]),
    .ram_din(o_ram_din[1]), .ram_dout(i_ram_dout[1]),
    .io_rd(o_io_rd[1]), .io_we(o_io_we[1]), .io_addr(o_io_addr[1]), .io_din(o_io_din[1]),
`ifdef MIO_TIMEOUT_EN
    .io_ack(io_ack), .bus_err(o_bus_err[1]),
`endif
    .io_dout(io_val)
  );

  typedef struct {
    int          lat;
    logic [31:0] din;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_din [2];
  int          io_lat;

  function automatic logic rdy(input int d);
    return (d == 0) ? b0.MIO_ready : b1.MIO_ready;
  endfunction

  function automatic logic [31:0] din(input int d);
    return (d == 0) ? b0.Data_in : b1.Data_in;
  endfunction

  function automatic logic [3:0] flags(input int d);
    return {o_ram_en[d], o_ram_we[d], o_io_rd[d], o_io_we[d]};
  endfunction

  function automatic logic any_out(input int d);
`ifdef MIO_TIMEOUT_EN
    return |{din(d), rdy(d), flags(d), o_ram_addr[d], o_ram_din[d], o_io_addr[d], o_io_din[d], o_bus_err[d]};
`else
    return |{din(d), rdy(d), flags(d), o_ram_addr[d], o_ram_din[d], o_io_addr[d], o_io_din[d]};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input logic mio,
                       input logic [31:0] addr, input logic [31:0] data);
    if (d == 0) begin
      b0.MemRead = rd; b0.MemWrite = wr; b0.CPU_MIO = mio; b0.addr_bus = addr; b0.Data_out = data;
    end else begin
      b1.MemRead = rd; b1.MemWrite = wr; b1.CPU_MIO = mio; b1.addr_bus = addr; b1.Data_out = data;
    end
  endtask

  task automatic run_xact(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_io, input int exp_lat,
                          input logic [31:0] exp_din, input string tag);
    exp_t e;
    int   lat = 0;
    int   extra = 0;
    bit   got = 0;
    logic [3:0] exp_flags;
    e.lat = exp_lat;
    e.din = exp_din;
    sb.push_back(e);
    exp_flags = exp_io ? {2'b00, ~wr, wr} : {1'b1, wr, 2'b00};
    drive(d, rd, wr, 1'b1, addr, wdata);
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if (c == 1) begin
        chk({tag, "/strobe"}, flags(d), exp_flags);
        if (exp_io) begin
          chk({tag, "/io_addr"}, o_io_addr[d], addr);
          if (wr) chk({tag, "/io_din"}, o_io_din[d], wdata);
        end else begin
          chk({tag, "/ram_addr"}, o_ram_addr[d], addr[AW+1:2]);
          if (wr) chk({tag, "/ram_din"}, o_ram_din[d], wdata);
        end
        // Scramble the request fields: the DUT must keep what it latched.
        drive(d, rd, wr, 1'b1, ~addr, ~wdata);
      end else if (flags(d) != 4'b0000) begin
        extra++;
      end
      if (rdy(d)) begin
        got = 1;
        lat = c;
        drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    if (!got) begin
      drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
      chk({tag, "/ready_timeout"}, 1'b0, 1'b1);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk({tag, "/latency"}, 64'(lat), 64'(e.lat));
      chk({tag, "/data_in"}, din(d), e.din);
    end
    chk({tag, "/extra_strobe"}, 64'(extra), 64'd0);
    tick();
    chk({tag, "/ready_pulse"}, rdy(d), 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    io_val = '0;
`ifdef MIO_TIMEOUT_EN
    io_ack = 1'b1;
    io_lat = 3;
`else
    io_lat = 4;
`endif
    last_din[0] = '0;
    last_din[1] = '0;
    tick();
    tick();
    chk("reset_outs_dut0", any_out(0), 1'b0);
    chk("reset_outs_dut1", any_out(1), 1'b0);
    reset = 1'b0;

    run_xact(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 2, 32'h1234_5678, "ram_rd_w0");
    last_din[0] = 32'h1234_5678;

    run_xact(1, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_0001, 1'b0, 5, last_din[1], "ram_wr_w3");

    io_val = 32'h0000_00A5;
    run_xact(0, 1'b1, 1'b0, 32'hE000_0004, 32'h0, 1'b1, io_lat, 32'h0000_00A5, "io_rd");
    last_din[0] = 32'h0000_00A5;

    run_xact(1, 1'b0, 1'b1, 32'hF000_0100, 32'h0000_0055, 1'b1, io_lat, last_din[1], "io_wr");

    // Top nibble 4'hD is still RAM space.
    run_xact(0, 1'b1, 1'b0, 32'hDFFF_FFF0, 32'h0, 1'b0, 2, 32'h5A00_03FC, "ram_rd_decode_d");
    last_din[0] = 32'h5A00_03FC;

    drive(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, '0);
    act = 0;
    repeat (5) begin
      tick();
      if (rdy(0) || (flags(0) != 4'b0000)) act++;
    end
    chk("no_ownership_idle", 64'(act), 64'd0);
    run_xact(0, 1'b1, 1'b1, 32'h0000_0080, 32'h1111_2222, 1'b0, 2, last_din[0], "rd_wr_priority");

`ifdef MIO_TIMEOUT_EN
    chk("bus_err_before_timeout", o_bus_err[0], 1'b0);
    io_ack = 1'b0;
    run_xact(0, 1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b1, 10, 32'hDEAD_BEEF, "io_timeout");
    chk("bus_err_set", o_bus_err[0], 1'b1);
    chk("bus_err_other_dut", o_bus_err[1], 1'b0);
    run_xact(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 2, 32'h1234_5678, "ram_after_timeout");
    chk("bus_err_sticky", o_bus_err[0], 1'b1);
    io_ack = 1'b1;
`endif

    drive(1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, '0);
    tick();
    tick();
    chk("wait_no_ready", rdy(1), 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    chk("reset_in_wait_dut1", any_out(1), 1'b0);
    chk("reset_in_wait_dut0", any_out(0), 1'b0);
    reset = 1'b0;
    act = 0;
    repeat (6) begin
      tick();
      if (rdy(1) || (flags(1) != 4'b0000)) act++;
    end
    chk("aborted_no_ready", 64'(act), 64'd0);
    last_din[0] = '0;
    last_din[1] = '0;
    run_xact(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 5, 32'h5A00_0008, "ram_rd_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
